// File: rtl/piece_queue.sv
// 7-bag piece generator with preview FIFO and active-piece rotation state; HOLD_EN adds a hold slot.
// Spawn/hold/rotate take effect one cycle after the request; spawn_req waits through FILL/REFILL.
module piece_queue #(
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          RETRY_MAX     = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       spawn_req,
  output logic                       spawn_ack,
  input  logic                       rot_cw,
  input  logic                       rot_ccw,
  input  logic                       rot_undo,
`ifdef HOLD_EN
  input  logic                       hold_req,
  output logic [2:0]                 hold_type,
  output logic                       hold_valid,
`endif
  output logic                       ready,
  output logic [2:0]                 active_type,
  output logic [1:0]                 active_rot,
  output logic [15:0]                active_mask,
  output logic [3*PREVIEW_DEPTH-1:0] preview_types,
  output logic [15:0]                preview0_mask
);

  localparam int CW = $clog2(PREVIEW_DEPTH + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [CW-1:0] LAST    = CW'(PREVIEW_DEPTH - 1);
  localparam logic [RW-1:0] RETRY_C = RW'(RETRY_MAX);

  typedef enum logic [1:0] {FILL, IDLE, REFILL} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [6:0]    bag_used;
  logic [RW-1:0] retry_cnt;
  logic [CW-1:0] count;
  logic [2:0]    slot [PREVIEW_DEPTH];
  logic [1:0]    prev_rot;

  function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] r);
    logic [15:0] m;
    case (t)
      3'd0: m = r[0] ? 16'h2222 : 16'h0F00;
      3'd1: case (r) 2'd0: m = 16'h0E40; 2'd1: m = 16'h4C40; 2'd2: m = 16'h04E0; default: m = 16'h4640; endcase
      3'd2: case (r) 2'd0: m = 16'h0E80; 2'd1: m = 16'hC440; 2'd2: m = 16'h02E0; default: m = 16'h4460; endcase
      3'd3: case (r) 2'd0: m = 16'h0E20; 2'd1: m = 16'h44C0; 2'd2: m = 16'h08E0; default: m = 16'h6440; endcase
      3'd4: m = r[0] ? 16'h8C40 : 16'h06C0;
      3'd5: m = r[0] ? 16'h2640 : 16'h0C60;
      default: m = 16'h0660;
    endcase
    return m;
  endfunction

  logic [15:0] lfsr_next;
  logic [2:0]  cand, fallback, push_type;
  logic        cand_ok, drawing, push;
  logic [6:0]  bag_set;

  assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
  assign cand      = lfsr[2:0];
  assign cand_ok   = (cand != 3'd7) && !bag_used[cand];
  assign drawing   = (state != IDLE);
  assign push      = drawing && (cand_ok || retry_cnt == RETRY_C);
  assign push_type = cand_ok ? cand : fallback;
  assign bag_set   = bag_used | (7'b1 << push_type);

  always_comb begin
    fallback = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (!bag_used[i]) fallback = 3'(i);
  end

  logic       do_spawn, load, shift;
  logic [2:0] load_type;
  assign do_spawn = (state == IDLE) && spawn_req;
`ifdef HOLD_EN
  logic hold_used, hold_ok;
  assign hold_ok   = (state == IDLE) && !spawn_req && hold_req && !hold_used;
  assign load      = do_spawn || hold_ok;
  assign shift     = do_spawn || (hold_ok && !hold_valid);
  assign load_type = (hold_ok && hold_valid) ? hold_type : slot[0];
`else
  assign load      = do_spawn;
  assign shift     = do_spawn;
  assign load_type = slot[0];
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= FILL;
      lfsr        <= SEED;
      bag_used    <= 7'd0;
      retry_cnt   <= '0;
      count       <= '0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) slot[i] <= 3'd0;
      ready       <= 1'b0;
      spawn_ack   <= 1'b0;
      active_type <= 3'd0;
      active_rot  <= 2'd0;
      prev_rot    <= 2'd0;
`ifdef HOLD_EN
      hold_used   <= 1'b0;
      hold_valid  <= 1'b0;
      hold_type   <= 3'd0;
`endif
    end else begin
      spawn_ack <= 1'b0;
      if (drawing) begin
        lfsr <= lfsr_next;
        if (push) begin
          bag_used  <= (bag_set == 7'h7F) ? 7'd0 : bag_set;
          retry_cnt <= '0;
          count     <= count + 1'b1;
          for (int i = 0; i < PREVIEW_DEPTH; i++)
            if (count == CW'(i)) slot[i] <= push_type;
          if (state == REFILL || count == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
        end
      end

      if (shift) begin
        for (int i = 0; i < PREVIEW_DEPTH - 1; i++) slot[i] <= slot[i+1];
        slot[PREVIEW_DEPTH-1] <= 3'd0;
        count <= count - 1'b1;
        state <= REFILL;
      end

      // A load (spawn or hold) overrides any rotate in the same cycle.
      if (load) begin
        active_type <= load_type;
        active_rot  <= 2'd0;
        prev_rot    <= 2'd0;
        spawn_ack   <= 1'b1;
      end else if (ready) begin
        if (rot_undo) begin
          active_rot <= prev_rot;
        end else if (rot_cw ^ rot_ccw) begin
          prev_rot   <= active_rot;
          active_rot <= rot_cw ? active_rot + 2'd1 : active_rot - 2'd1;
        end
      end

`ifdef HOLD_EN
      if (do_spawn) hold_used <= 1'b0;
      if (hold_ok) begin
        hold_used  <= 1'b1;
        hold_valid <= 1'b1;
        hold_type  <= active_type;
      end
`endif
    end
  end

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_prev
    assign preview_types[3*g +: 3] = slot[g];
  end

  assign active_mask   = shape(active_type, active_rot);
  assign preview0_mask = shape(slot[0], 2'd0);

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: timing-free bag model feeds a spawn scoreboard; rotation driven from a vector table.
module tb_piece_queue;
  localparam int PD = 3;
  localparam int RM = 8;

  localparam logic [15:0] SHP [0:6][0:3] = '{
    '{16'h0F00, 16'h2222, 16'h0F00, 16'h2222},
    '{16'h0E40, 16'h4C40, 16'h04E0, 16'h4640},
    '{16'h0E80, 16'hC440, 16'h02E0, 16'h4460},
    '{16'h0E20, 16'h44C0, 16'h08E0, 16'h6440},
    '{16'h06C0, 16'h8C40, 16'h06C0, 16'h8C40},
    '{16'h0C60, 16'h2640, 16'h0C60, 16'h2640},
    '{16'h0660, 16'h0660, 16'h0660, 16'h0660}};

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          spawn_req = 1'b0, rot_cw = 1'b0, rot_ccw = 1'b0, rot_undo = 1'b0;
  logic          spawn_ack, ready;
  logic [2:0]    active_type;
  logic [1:0]    active_rot;
  logic [15:0]   active_mask, preview0_mask;
  logic [3*PD-1:0] preview_types;
`ifdef HOLD_EN
  logic          hold_req = 1'b0;
  logic [2:0]    hold_type;
  logic          hold_valid;
`endif

  piece_queue #(.PREVIEW_DEPTH(PD), .SEED(16'hACE1), .RETRY_MAX(RM)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .spawn_req(spawn_req), .spawn_ack(spawn_ack),
    .rot_cw(rot_cw), .rot_ccw(rot_ccw), .rot_undo(rot_undo),
`ifdef HOLD_EN
    .hold_req(hold_req), .hold_type(hold_type), .hold_valid(hold_valid),
`endif
    .ready(ready), .active_type(active_type), .active_rot(active_rot),
    .active_mask(active_mask), .preview_types(preview_types), .preview0_mask(preview0_mask));

  always #5 Clk = ~Clk;

  int tests = 0, fails = 0;
  logic [2:0] mseq [$];
  logic [2:0] exp_q [$];
  int nsp = 0;
  logic [2:0] last_type;

  typedef struct { logic cw; logic ccw; logic undo; logic [1:0] rot; } rvec_t;
  rvec_t rv [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Every FILL/REFILL cycle consumes exactly one LFSR value, so the push order is timing-independent.
  task automatic build_model();
    logic [15:0] lf;
    logic [6:0]  bag;
    int          retry;
    logic [2:0]  c, t;
    logic        ok;
    lf = 16'hACE1; bag = 7'd0; retry = 0;
    while (mseq.size() < 40) begin
      c  = lf[2:0];
      ok = (c != 3'd7) && !bag[c];
      if (ok || retry == RM) begin
        t = c;
        if (!ok) for (int i = 6; i >= 0; i--) if (!bag[i]) t = 3'(i);
        mseq.push_back(t);
        bag = bag | (7'b1 << t);
        if (bag == 7'h7F) bag = 7'd0;
        retry = 0;
      end else begin
        retry++;
      end
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !ready; i++) begin
      @(posedge Clk); #1;
    end
    check("ready_in_budget", {31'd0, ready}, 32'd1);
  endtask

  task automatic check_preview();
    logic a, b, c;
    check("preview_types", {23'd0, preview_types}, {23'd0, mseq[2], mseq[1], mseq[0]});
    check("preview0_mask", {16'd0, preview0_mask}, {16'd0, SHP[mseq[0]][0]});
    a = preview_types[2:0] != preview_types[5:3];
    b = preview_types[2:0] != preview_types[8:6];
    c = preview_types[5:3] != preview_types[8:6];
    check("preview_distinct", {31'd0, a & b & c}, 32'd1);
  endtask

  task automatic spawn_one(input logic cw, input logic settle);
    logic got;
    logic [2:0] e;
    if (settle) repeat (2 * (RM + 1) + 2) @(posedge Clk);
    #1;
    exp_q.push_back(mseq[nsp]);
    nsp++;
    spawn_req = 1'b1;
    rot_cw = cw;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge Clk); #1;
      rot_cw = 1'b0;
      if (spawn_ack) got = 1'b1;
    end
    spawn_req = 1'b0;
    if (!got) begin
      check("spawn_ack_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      last_type = e;
      check("spawn_type", {29'd0, active_type}, {29'd0, e});
      check("spawn_rot", {30'd0, active_rot}, 32'd0);
      check("spawn_mask", {16'd0, active_mask}, {16'd0, SHP[e][0]});
    end
  endtask

  task automatic run_14_spawns();
    logic [6:0] p1, p2;
    p1 = 7'd0; p2 = 7'd0;
    for (int k = 0; k < 14; k++) begin
      spawn_one(1'b0, 1'b0);
      if (k < 7) p1 = p1 | (7'b1 << active_type);
      else       p2 = p2 | (7'b1 << active_type);
      @(posedge Clk); #1;
      check("ack_one_cycle", {31'd0, spawn_ack}, 32'd0);
    end
    check("bag_perm_1_7", {25'd0, p1}, 32'h7F);
    check("bag_perm_8_14", {25'd0, p2}, 32'h7F);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_ack"}, {31'd0, spawn_ack}, 32'd0);
    check({tag, "_type"}, {29'd0, active_type}, 32'd0);
    check({tag, "_rot"}, {30'd0, active_rot}, 32'd0);
    check({tag, "_preview"}, {23'd0, preview_types}, 32'd0);
    check({tag, "_mask"}, {16'd0, active_mask}, 32'h0F00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0]  = '{1'b1, 1'b0, 1'b0, 2'd1};
    rv[1]  = '{1'b1, 1'b0, 1'b0, 2'd2};
    rv[2]  = '{1'b1, 1'b0, 1'b0, 2'd3};
    rv[3]  = '{1'b1, 1'b0, 1'b0, 2'd0};
    rv[4]  = '{1'b0, 1'b1, 1'b0, 2'd3};
    rv[5]  = '{1'b0, 1'b0, 1'b1, 2'd0};
    rv[6]  = '{1'b1, 1'b1, 1'b0, 2'd0};
    rv[7]  = '{1'b1, 1'b0, 1'b0, 2'd1};
    rv[8]  = '{1'b1, 1'b1, 1'b1, 2'd0};
    rv[9]  = '{1'b0, 1'b0, 1'b1, 2'd0};
    rv[10] = '{1'b0, 1'b1, 1'b0, 2'd3};
    rv[11] = '{1'b0, 1'b1, 1'b0, 2'd2};
    rv[12] = '{1'b0, 1'b0, 1'b1, 2'd3};
    build_model();

    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");

    // Inputs asserted while filling must have no effect.
    @(negedge Clk);
    Reset_n = 1'b1; rot_ccw = 1'b1; rot_undo = 1'b1; spawn_req = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    rot_ccw = 1'b0; rot_undo = 1'b0; spawn_req = 1'b0;
    check("fill_ready_low", {31'd0, ready}, 32'd0);
    check("fill_rot_ignored", {30'd0, active_rot}, 32'd0);
    wait_ready(PD * (RM + 1) + 2 - 2);
    check_preview();
    check("no_spawn_during_fill", {29'd0, active_type}, 32'd0);

    run_14_spawns();

    for (int v = 0; v < 13; v++) begin
      rot_cw = rv[v].cw; rot_ccw = rv[v].ccw; rot_undo = rv[v].undo;
      @(posedge Clk); #1;
      rot_cw = 1'b0; rot_ccw = 1'b0; rot_undo = 1'b0;
      check($sformatf("rot_vec%0d", v), {30'd0, active_rot}, {30'd0, rv[v].rot});
      check($sformatf("rot_mask%0d", v), {16'd0, active_mask}, {16'd0, SHP[last_type][rv[v].rot]});
    end

    spawn_one(1'b1, 1'b1);

    // Reset while the queue is refilling after a spawn.
    spawn_one(1'b0, 1'b1);
    Reset_n = 1'b0;
    #2;
    check_reset_outputs("midrefill");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    wait_ready(PD * (RM + 1) + 2);
    check_preview();
    nsp = 0;
    exp_q.delete();
    run_14_spawns();

`ifdef HOLD_EN
    repeat (2 * (RM + 1) + 2) @(posedge Clk);
    #1;
    hold_req = 1'b1;
    @(posedge Clk); #1;
    hold_req = 1'b0;
    check("hold1_ack", {31'd0, spawn_ack}, 32'd1);
    check("hold1_valid", {31'd0, hold_valid}, 32'd1);
    check("hold1_type", {29'd0, hold_type}, {29'd0, mseq[13]});
    check("hold1_active", {29'd0, active_type}, {29'd0, mseq[14]});
    nsp = 15;
    repeat (2 * (RM + 1) + 2) @(posedge Clk);
    #1;
    hold_req = 1'b1;
    @(posedge Clk); #1;
    hold_req = 1'b0;
    check("hold2_ignored", {29'd0, active_type}, {29'd0, mseq[14]});
    spawn_one(1'b0, 1'b0);
    repeat (2 * (RM + 1) + 2) @(posedge Clk);
    #1;
    hold_req = 1'b1;
    @(posedge Clk); #1;
    hold_req = 1'b0;
    check("hold3_active", {29'd0, active_type}, {29'd0, mseq[13]});
    check("hold3_type", {29'd0, hold_type}, {29'd0, mseq[15]});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
